// File: rtl/fsm_seq_driver_if.sv
// Bundle between the sequence driver and its user/target: run handshake,
// pattern and response words, plus the serial a -> out1/out2 link.
`timescale 1ns/1ps
interface fsm_seq_driver_if #(
    parameter int LEN = 8
);
    logic           start;
    logic [LEN-1:0] pattern;
    logic           out1;
    logic           out2;
    logic           a;
    logic           busy;
    logic           done;
    logic [LEN-1:0] resp1;
    logic [LEN-1:0] resp2;

    // master: the driver itself; slave: whoever requests runs and hosts the target
    modport master (
        input  start, pattern, out1, out2,
        output a, busy, done, resp1, resp2
    );

    modport slave (
        output start, pattern, out1, out2,
        input  a, busy, done, resp1, resp2
    );
endinterface

// File: rtl/fsm_seq_driver.sv
// Serialises a latched pattern onto a (LSB first), captures the target's
// registered out1/out2 one cycle later per bit, then pulses done.
`timescale 1ns/1ps
module fsm_seq_driver #(
    parameter int LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    fsm_seq_driver_if.master    bus
);
    localparam int IW = $clog2(LEN) + 1;

    if (LEN < 2 || LEN > 32) begin : g_len_check
        $error("fsm_seq_driver: LEN must be within 2..32");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic [LEN-1:0] shadow_reg, shadow_next;
    logic           a_reg, a_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic [LEN-1:0] resp1_reg, resp1_next;
    logic [LEN-1:0] resp2_reg, resp2_next;
    logic [LEN-1:0] shadow_shifted;
    logic           accept;
    logic           last_drive;
    logic           capture_en;

    assign accept     = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_drive = (state_reg == DRIVE) && (idx_reg == IW'(LEN - 1));
    // In DRIVE and CAPTURE the bit whose response is on out1/out2 is always idx_reg-1
    assign capture_en = (state_reg == DRIVE) || (state_reg == CAPTURE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            shadow_reg <= '0;
            a_reg      <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            resp1_reg  <= '0;
            resp2_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            shadow_reg <= shadow_next;
            a_reg      <= a_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            resp1_reg  <= resp1_next;
            resp2_reg  <= resp2_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        shadow_next = shadow_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    state_next  = DRIVE;
                    shadow_next = bus.pattern;
                    idx_next    = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            DRIVE: begin
                idx_next = idx_reg + 1'b1;
                if (last_drive) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shifting by LEN (past the last bit) yields 0, which is what a must show in CAPTURE
    always_comb begin
        shadow_shifted = shadow_reg >> idx_next;
        a_next         = 1'b0;
        if (accept) begin
            a_next = bus.pattern[0];
        end else if (state_next == DRIVE) begin
            a_next = shadow_shifted[0];
        end
        busy_next = (state_next == DRIVE) || (state_next == CAPTURE);
        done_next = (state_next == DONE);
    end

    for (genvar gi = 0; gi < LEN; gi++) begin : g_resp
        logic hit;
        assign hit            = capture_en && (idx_reg == IW'(gi + 1));
        assign resp1_next[gi] = accept ? 1'b0 : (hit ? bus.out1 : resp1_reg[gi]);
        assign resp2_next[gi] = accept ? 1'b0 : (hit ? bus.out2 : resp2_reg[gi]);
    end

    assign bus.a     = a_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.resp1 = resp1_reg;
    assign bus.resp2 = resp2_reg;
endmodule
